// File: rtl/ringbuffer.sv
// ---------------------------------------------------------------------------
// ringbuffer
//
// Pointer and status controller for a power-of-two circular buffer. The data
// itself lives in an external RAM; this block only tracks which slot the
// producer writes next and which slot the consumer reads next. It also flags
// the empty, full, overflow and underflow conditions.
//
// Parameters:
//   BITS        address width; buffer depth is 2**BITS entries
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   write_done  producer finished the slot at write_addr (rising edge counts)
//   read_done   consumer finished the slot at read_addr (rising edge counts)
//   write_addr  next slot to write
//   read_addr   next slot to read
//   empty       buffer holds no entries
//   full        buffer holds 2**BITS entries
//   overflow    sticky: a write arrived while full
//   underflow   sticky: a read arrived while empty
//   level       entry count, 0..2**BITS (only with RINGBUFFER_LEVEL_EN)
//
// Optional feature macro: RINGBUFFER_LEVEL_EN adds the level output.
// ---------------------------------------------------------------------------
module ringbuffer #(
  parameter int BITS = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_done,
  input  logic            read_done,
  output logic [BITS-1:0] write_addr,
  output logic [BITS-1:0] read_addr,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
`ifdef RINGBUFFER_LEVEL_EN
  ,
  output logic [BITS:0]   level
`endif
);

  localparam logic [BITS:0] PTR_ONE = {{BITS{1'b0}}, 1'b1};

  // Each pointer carries one extra wrap bit. With it, full and empty can be
  // told apart when the address bits are equal.
  logic [BITS:0] wptr_q, wptr_d;
  logic [BITS:0] rptr_q, rptr_d;
  logic          wd_q, rd_q;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          wr_ev, rd_ev;
  logic          empty_w, full_w;

  assign wr_ev   = write_done & ~wd_q;
  assign rd_ev   = read_done & ~rd_q;

  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[BITS-1:0] == rptr_q[BITS-1:0]) &&
                   (wptr_q[BITS] != rptr_q[BITS]);

  // Both events are judged against the pre-edge state. A simultaneous write
  // and read on an empty buffer therefore accepts the write and flags the read
  // as underflow. On a full buffer it accepts the read and flags the write as
  // overflow.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr_ev) begin
      if (full_w) begin
        ovf_d = 1'b1;
      end else begin
        wptr_d = wptr_q + PTR_ONE;
      end
    end
    if (rd_ev) begin
      if (empty_w) begin
        unf_d = 1'b1;
      end else begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
  end

  // The edge-detect history resets to 0. A strobe that is already high when
  // reset releases is therefore counted once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wd_q   <= 1'b0;
      rd_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wd_q   <= write_done;
      rd_q   <= read_done;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign write_addr = wptr_q[BITS-1:0];
  assign read_addr  = rptr_q[BITS-1:0];
  assign empty      = empty_w;
  assign full       = full_w;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

`ifdef RINGBUFFER_LEVEL_EN
  // Subtraction modulo 2**(BITS+1) yields 0..2**BITS.
  assign level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_ringbuffer.sv
// ---------------------------------------------------------------------------
// tb_ringbuffer
//
// Directed self-checking bench for ringbuffer with BITS = 7 (depth 128).
// Expected values are hand-computed constants. The level output is checked
// only when RINGBUFFER_LEVEL_EN is defined.
// ---------------------------------------------------------------------------
module tb_ringbuffer;

  localparam int BITS = 7;

  logic            clk;
  logic            reset;
  logic            write_done;
  logic            read_done;
  logic [BITS-1:0] write_addr;
  logic [BITS-1:0] read_addr;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;
`ifdef RINGBUFFER_LEVEL_EN
  logic [BITS:0]   level;
`endif

  int n_cmp;
  int n_err;

  ringbuffer #(.BITS(BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_done (write_done),
    .read_done  (read_done),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef RINGBUFFER_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef RINGBUFFER_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`else
    if (exp < 0) $display("level %s not present", tag);
`endif
  endtask

  // Asserts reset between edges, releases it between edges, and leaves the
  // bench 1 time unit after a rising edge.
  task automatic do_reset();
    write_done = 1'b0;
    read_done  = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic w, input logic r);
    write_done = w;
    read_done  = r;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    read_done  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    write_done = 1'b0;
    read_done  = 1'b0;
    #2;

    // Reset state, observed while reset is still low.
    reset = 1'b0;
    #1;
    check("rst_waddr", 32'(write_addr), 32'd0);
    check("rst_raddr", 32'(read_addr), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check_level("rst_level", 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One write followed by one read.
    pulse(1'b1, 1'b0);
    check("w1_waddr", 32'(write_addr), 32'd1);
    check("w1_empty", 32'(empty), 32'd0);
    pulse(1'b0, 1'b1);
    check("wr1_waddr", 32'(write_addr), 32'd1);
    check("wr1_raddr", 32'(read_addr), 32'd1);
    check("wr1_empty", 32'(empty), 32'd1);
    check("wr1_full", 32'(full), 32'd0);

    // Fill to 128 entries, then overflow.
    do_reset();
    for (int i = 0; i < 128; i++) pulse(1'b1, 1'b0);
    check("fill_waddr", 32'(write_addr), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_empty", 32'(empty), 32'd0);
    check("fill_ovf", 32'(overflow), 32'd0);
    check_level("fill_level", 128);
    pulse(1'b1, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_waddr", 32'(write_addr), 32'd0);
    check("ovf_full", 32'(full), 32'd1);

    // Drain all 128 entries, then underflow.
    for (int i = 0; i < 128; i++) pulse(1'b0, 1'b1);
    check("drain_raddr", 32'(read_addr), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_full", 32'(full), 32'd0);
    check("drain_unf", 32'(underflow), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    pulse(1'b0, 1'b1);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_raddr", 32'(read_addr), 32'd0);

    // Simultaneous write and read with 5 entries held.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    check("sim5_pre_waddr", 32'(write_addr), 32'd5);
    pulse(1'b1, 1'b1);
    check("sim5_waddr", 32'(write_addr), 32'd6);
    check("sim5_raddr", 32'(read_addr), 32'd1);
    check("sim5_empty", 32'(empty), 32'd0);
    check("sim5_unf", 32'(underflow), 32'd0);
    check_level("sim5_level", 5);

    // Simultaneous write and read on an empty buffer.
    do_reset();
    pulse(1'b1, 1'b1);
    check("sim0_waddr", 32'(write_addr), 32'd1);
    check("sim0_raddr", 32'(read_addr), 32'd0);
    check("sim0_unf", 32'(underflow), 32'd1);
    check("sim0_ovf", 32'(overflow), 32'd0);
    check("sim0_empty", 32'(empty), 32'd0);

    // Simultaneous write and read on a full buffer.
    do_reset();
    for (int i = 0; i < 128; i++) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("simf_waddr", 32'(write_addr), 32'd0);
    check("simf_raddr", 32'(read_addr), 32'd1);
    check("simf_ovf", 32'(overflow), 32'd1);
    check("simf_full", 32'(full), 32'd0);
    check_level("simf_level", 127);

    // A write strobe held high for 10 cycles counts once.
    do_reset();
    write_done = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    write_done = 1'b0;
    @(posedge clk);
    #1;
    check("held_waddr", 32'(write_addr), 32'd1);

    // A strobe already high when reset releases counts once at the first edge.
    write_done = 1'b0;
    read_done  = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    write_done = 1'b1;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_waddr", 32'(write_addr), 32'd1);
    write_done = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 37; i++) pulse(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b0);
    check("mid_raddr_pre", 32'(read_addr), 32'd21);
    do_reset();
    for (int i = 0; i < 37; i++) pulse(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) pulse(1'b0, 1'b1);
    check("mid_waddr", 32'(write_addr), 32'd37);
    check("mid_raddr", 32'(read_addr), 32'd20);
    #2;
    reset = 1'b0;
    #1;
    check("async_waddr", 32'(write_addr), 32'd0);
    check("async_raddr", 32'(read_addr), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_full", 32'(full), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);
    check("async_unf", 32'(underflow), 32'd0);
    check_level("async_level", 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
